// File: rtl/pipelined_cla_adder.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready handshakes.
// A global stall freezes every stage whenever a valid result waits at the output.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  logic w_advance;

  logic [WIDTH-1:0] r_inA;
  logic [WIDTH-1:0] r_inB;
  logic             r_inC0;
  logic             r_inValid;

  logic             r_outValid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  assign w_advance = ~r_outValid | out_ready;
  assign in_ready  = w_advance & rst_n;

  // Subtraction is folded in here so the rest of the pipe only ever adds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inValid <= 1'b0;
      r_inA     <= '0;
      r_inB     <= '0;
      r_inC0    <= 1'b0;
    end else if (w_advance) begin
      r_inValid <= in_valid;
      if (in_valid) begin
        r_inA  <= a;
        r_inB  <= sub ? ~b : b;
        r_inC0 <= sub | cin;
      end
    end
  end

  logic [WIDTH-1:0] w_bitP;
  logic [WIDTH-1:0] w_bitG;
  logic [NG-1:0]    w_grpP;
  logic [NG-1:0]    w_grpG;

  always_comb begin
    logic acc;
    logic prod;
    acc    = 1'b0;
    prod   = 1'b1;
    w_bitP = r_inA ^ r_inB;
    w_bitG = r_inA & r_inB;
    w_grpP = '0;
    w_grpG = '0;
    for (int j = 0; j < NG; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int k = GROUP - 1; k >= 0; k--) begin
        acc  = acc | (w_bitG[j*GROUP+k] & prod);
        prod = prod & w_bitP[j*GROUP+k];
      end
      w_grpG[j] = acc;
      w_grpP[j] = prod;
    end
  end

  logic [WIDTH-1:0] w_pgP;
  logic [WIDTH-1:0] w_pgG;
  logic [NG-1:0]    w_pgGrpP;
  logic [NG-1:0]    w_pgGrpG;
  logic             w_pgC0;
  logic             w_pgValid;

  if (STAGES >= 2) begin : g_pgReg
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_g;
    logic [NG-1:0]    r_gp;
    logic [NG-1:0]    r_gg;
    logic             r_c0;
    logic             r_valid;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_p     <= '0;
        r_g     <= '0;
        r_gp    <= '0;
        r_gg    <= '0;
        r_c0    <= 1'b0;
      end else if (w_advance) begin
        r_valid <= r_inValid;
        r_p     <= w_bitP;
        r_g     <= w_bitG;
        r_gp    <= w_grpP;
        r_gg    <= w_grpG;
        r_c0    <= r_inC0;
      end
    end

    assign w_pgP     = r_p;
    assign w_pgG     = r_g;
    assign w_pgGrpP  = r_gp;
    assign w_pgGrpG  = r_gg;
    assign w_pgC0    = r_c0;
    assign w_pgValid = r_valid;
  end else begin : g_pgPass
    assign w_pgP     = w_bitP;
    assign w_pgG     = w_bitG;
    assign w_pgGrpP  = w_grpP;
    assign w_pgGrpG  = w_grpG;
    assign w_pgC0    = r_inC0;
    assign w_pgValid = r_inValid;
  end

  // Each group carry is a flat sum-of-products over all lower groups and c0.
  logic [NG:0] w_grpC;

  always_comb begin
    logic acc;
    logic prod;
    acc       = 1'b0;
    prod      = 1'b1;
    w_grpC    = '0;
    w_grpC[0] = w_pgC0;
    for (int j = 1; j <= NG; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int m = j - 1; m >= 0; m--) begin
        acc  = acc | (w_pgGrpG[m] & prod);
        prod = prod & w_pgGrpP[m];
      end
      w_grpC[j] = acc | (prod & w_pgC0);
    end
  end

  logic [WIDTH-1:0] w_csP;
  logic [WIDTH-1:0] w_csG;
  logic [NG:0]      w_csC;
  logic             w_csValid;

  if (STAGES == 3) begin : g_csReg
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_g;
    logic [NG:0]      r_c;
    logic             r_valid;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_p     <= '0;
        r_g     <= '0;
        r_c     <= '0;
      end else if (w_advance) begin
        r_valid <= w_pgValid;
        r_p     <= w_pgP;
        r_g     <= w_pgG;
        r_c     <= w_grpC;
      end
    end

    assign w_csP     = r_p;
    assign w_csG     = r_g;
    assign w_csC     = r_c;
    assign w_csValid = r_valid;
  end else begin : g_csPass
    assign w_csP     = w_pgP;
    assign w_csG     = w_pgG;
    assign w_csC     = w_grpC;
    assign w_csValid = w_pgValid;
  end

  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_unusedTopG;

  always_comb begin
    logic acc;
    logic prod;
    acc     = 1'b0;
    prod    = 1'b1;
    w_carry = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int k = i - 1; k >= (i / GROUP) * GROUP; k--) begin
        acc  = acc | (w_csG[k] & prod);
        prod = prod & w_csP[k];
      end
      w_carry[i] = acc | (prod & w_csC[i/GROUP]);
    end
    w_sum  = w_csP ^ w_carry;
    w_cout = w_csC[NG];
    w_ovf  = w_carry[WIDTH-1] ^ w_csC[NG];
  end

  // A group's top-bit generate only feeds the next group carry, already in w_csC.
  always_comb begin
    w_unusedTopG = 1'b0;
    for (int j = 0; j < NG; j++) begin
      w_unusedTopG = w_unusedTopG ^ w_csG[j*GROUP+GROUP-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_advance) begin
      r_outValid <= w_csValid;
      if (w_csValid) begin
        r_sum  <= w_sum;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
        r_zero <= (w_sum == '0);
      end
    end
  end

  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench: four adder configurations run in parallel, each checked every
// cycle against an arithmetic model of a globally stalled, fixed-latency pipe.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  int   nChecks = 0;
  int   nFails  = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : cfg
    localparam int W = (k == 0) ? 16 : (k == 1) ? 32 : (k == 2) ? 64 : 8;
    localparam int G = (k == 0) ? 4 : (k == 1) ? 4 : (k == 2) ? 8 : 2;
    localparam int S = (k == 0) ? 1 : (k == 1) ? 2 : 3;
    localparam int NRAND = 10000;

    localparam logic [W-1:0] ONES   = {W{1'b1}};
    localparam logic [W-1:0] ZERO   = {W{1'b0}};
    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] FIVE   = W'(5);
    localparam logic [W-1:0] SEVEN  = W'(7);
    localparam logic [W-1:0] MSB    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG2   = {{(W-1){1'b1}}, 1'b0};

    logic         rstN = 1'b0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         outValid;
    logic         outReady = 1'b1;
    logic [W-1:0] sumOut;
    logic         coutOut;
    logic         ovfOut;
    logic         zeroOut;
    logic         done = 1'b0;
    string        tag;

    pipelined_cla_adder #(.WIDTH(W), .GROUP(G), .STAGES(S)) dut (
      .clk      (clk),
      .rst_n    (rstN),
      .in_valid (inValid),
      .in_ready (inReady),
      .a        (opA),
      .b        (opB),
      .cin      (cin),
      .sub      (sub),
      .out_valid(outValid),
      .out_ready(outReady),
      .sum      (sumOut),
      .cout     (coutOut),
      .ovf      (ovfOut),
      .zero     (zeroOut)
    );

    // Returns {ovf, cout, sum} straight from the arithmetic definition.
    function automatic logic [W+1:0] refOp(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic c, input logic s);
      logic [W-1:0] beff;
      logic [W:0]   full;
      logic         ov;
      beff = s ? ~bv : bv;
      full = {1'b0, av} + {1'b0, beff} + {{W{1'b0}}, (s | c)};
      ov   = (av[W-1] == beff[W-1]) && (full[W-1] != av[W-1]);
      return {ov, full};
    endfunction

    function automatic logic [W-1:0] randOperand();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0:       return ONES;
        1:       return ZERO;
        2:       return MSB;
        3:       return MAXPOS;
        default: return r[W-1:0];
      endcase
    endfunction

    // Model: S+1 slots (input register plus S stages) that all shift together or all hold.
    logic         mV   [0:S];
    logic [W+1:0] mRes [0:S];
    logic         mStarted = 1'b0;
    int           mAccepted = 0;
    int           mDelivered = 0;

    always @(posedge clk) begin
      if (!rstN) begin
        for (int i = 0; i <= S; i++) mV[i] <= 1'b0;
        mStarted <= 1'b1;
      end else if (!mV[S] || outReady) begin
        for (int i = S; i >= 1; i--) begin
          mV[i]   <= mV[i-1];
          mRes[i] <= mRes[i-1];
        end
        mV[0]   <= inValid;
        mRes[0] <= refOp(opA, opB, cin, sub);
        if (inValid) mAccepted <= mAccepted + 1;
        if (mV[S]) mDelivered <= mDelivered + 1;
      end
    end

    always @(negedge clk) begin
      if (mStarted) begin
        checkOutput({tag, " out_valid"}, {63'd0, outValid}, {63'd0, mV[S]});
        checkOutput({tag, " in_ready"}, {63'd0, inReady},
                    {63'd0, (!mV[S] || outReady) && rstN});
        if (mV[S]) begin
          checkOutput({tag, " sum"}, 64'(sumOut), 64'(mRes[S][W-1:0]));
          checkOutput({tag, " cout"}, {63'd0, coutOut}, {63'd0, mRes[S][W]});
          checkOutput({tag, " ovf"}, {63'd0, ovfOut}, {63'd0, mRes[S][W+1]});
          checkOutput({tag, " zero"}, {63'd0, zeroOut}, {63'd0, mRes[S][W-1:0] == ZERO});
        end
      end
    end

    task automatic applyStimulus(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic c, input logic s);
      inValid = v;
      opA     = av;
      opB     = bv;
      cin     = c;
      sub     = s;
    endtask

    task automatic idleCycles(input int n);
      applyStimulus(1'b0, ZERO, ZERO, 1'b0, 1'b0);
      outReady = 1'b1;
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    // One op into an empty pipe; it must show up exactly S edges after acceptance.
    task automatic directedOp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c,
                              input logic s, input logic [W-1:0] es, input logic ec,
                              input logic eo, input logic ez, input string nm);
      outReady = 1'b1;
      applyStimulus(1'b1, av, bv, c, s);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, ZERO, ZERO, 1'b0, 1'b0);
      for (int i = 1; i <= S; i++) begin
        @(posedge clk);
        #1;
        if (i < S) checkOutput({tag, " ", nm, " early valid"}, {63'd0, outValid}, 64'd0);
      end
      checkOutput({tag, " ", nm, " valid"}, {63'd0, outValid}, 64'd1);
      checkOutput({tag, " ", nm, " sum"}, 64'(sumOut), 64'(es));
      checkOutput({tag, " ", nm, " cout"}, {63'd0, coutOut}, {63'd0, ec});
      checkOutput({tag, " ", nm, " ovf"}, {63'd0, ovfOut}, {63'd0, eo});
      checkOutput({tag, " ", nm, " zero"}, {63'd0, zeroOut}, {63'd0, ez});
    endtask

    initial begin
      int base;
      int delBase;
      int cycles;
      int sent;
      int stall;
      logic seen;
      tag = $sformatf("W%0d/G%0d/S%0d", W, G, S);

      rstN = 1'b0;
      outReady = 1'b1;
      for (int i = 0; i < 3; i++) begin
        applyStimulus(1'b1, randOperand(), randOperand(), 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput({tag, " reset out_valid"}, {63'd0, outValid}, 64'd0);
        checkOutput({tag, " reset in_ready"}, {63'd0, inReady}, 64'd0);
        checkOutput({tag, " reset sum"}, 64'(sumOut), 64'd0);
      end
      rstN = 1'b1;
      applyStimulus(1'b0, ZERO, ZERO, 1'b0, 1'b0);

      directedOp(ONES, ZERO, 1'b1, 1'b0, ZERO, 1'b1, 1'b0, 1'b1, "carry chain");
      directedOp(MAXPOS, ONE, 1'b0, 1'b0, MSB, 1'b0, 1'b1, 1'b0, "pos overflow");
      for (int c = 0; c < 2; c++) begin
        directedOp(FIVE, SEVEN, 1'(c), 1'b1, NEG2, 1'b0, 1'b0, 1'b0, "sub 5-7");
        directedOp(MSB, ONE, 1'(c), 1'b1, MAXPOS, 1'b1, 1'b1, 1'b0, "sub min-1");
      end
      idleCycles(S + 2);

      // Backpressure: 8 back-to-back ops, consumer stalls 4 cycles at the first result.
      base = mDelivered;
      sent = 0;
      stall = 0;
      seen = 1'b0;
      cycles = 0;
      while (mDelivered - base < 8 && cycles < 200) begin
        if (outValid) seen = 1'b1;
        if (seen && stall < 4) begin
          outReady = 1'b0;
          stall++;
        end else begin
          outReady = 1'b1;
        end
        applyStimulus(sent < 8, randOperand(), randOperand(), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
        @(negedge clk);
        if (!outReady) checkOutput({tag, " stall in_ready"}, {63'd0, inReady}, 64'd0);
        if (inValid && inReady) sent++;
        @(posedge clk);
        #1;
        cycles++;
      end
      checkOutput({tag, " backpressure delivered"}, 64'(mDelivered - base), 64'd8);
      idleCycles(S + 2);

      // Alternating bubbles: ops at even edges must surface at even offsets after S.
      for (int e = 0; e <= 8 + S; e++) begin
        outReady = 1'b1;
        applyStimulus(e < 8 && e % 2 == 0, randOperand(), randOperand(), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput({tag, $sformatf(" bubble edge %0d valid", e)}, {63'd0, outValid},
                    {63'd0, (e >= S) && ((e - S) % 2 == 0) && (e - S < 8)});
      end
      idleCycles(2);

      // Reset with two ops in flight: neither result may ever be delivered.
      base = mDelivered;
      outReady = 1'b0;
      applyStimulus(1'b1, randOperand(), randOperand(), 1'b0, 1'b0);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, randOperand(), randOperand(), 1'b0, 1'b1);
      @(posedge clk);
      #1;
      rstN = 1'b0;
      applyStimulus(1'b0, ZERO, ZERO, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rstN = 1'b1;
      outReady = 1'b1;
      checkOutput({tag, " mid reset sum"}, 64'(sumOut), 64'd0);
      for (int i = 0; i < S + 2; i++) begin
        checkOutput({tag, " mid reset valid"}, {63'd0, outValid}, 64'd0);
        @(posedge clk);
        #1;
      end
      checkOutput({tag, " mid reset delivered"}, 64'(mDelivered - base), 64'd0);

      // Random sweep with random valid/ready.
      base = mAccepted;
      delBase = mDelivered;
      cycles = 0;
      while (mAccepted - base < NRAND && cycles < 40000) begin
        applyStimulus($urandom_range(0, 3) != 0, randOperand(), randOperand(),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        outReady = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
        cycles++;
      end
      applyStimulus(1'b0, ZERO, ZERO, 1'b0, 1'b0);
      checkOutput({tag, " random accepted"}, 64'(mAccepted - base), 64'(NRAND));
      idleCycles(S + 4);
      checkOutput({tag, " random delivered"}, 64'(mDelivered - delBase), 64'(NRAND));
      done = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 60000; t++) begin
      if (cfg[0].done && cfg[1].done && cfg[2].done && cfg[3].done) break;
      @(posedge clk);
    end
    checkOutput("all configs done", {60'd0, cfg[3].done, cfg[2].done, cfg[1].done, cfg[0].done},
                64'hF);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
